// File: rtl/obstacle_manager.sv
// Multi-slot obstacle engine: per-frame scroll/spawn/retire of NUM_SLOTS obstacles,
// a registered per-pixel box query, and a sticky dino collision flag.
module obstacle_manager #(
    parameter int unsigned NUM_SLOTS  = 3,
    parameter int unsigned XW         = 11,
    parameter int unsigned TYPE_W     = 2,
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SPRITE_W   = 27,
    parameter int unsigned SPRITE_H   = 47,
    parameter int unsigned Y_TOP      = 203,
    parameter int unsigned MIN_GAP    = 200,
    parameter int unsigned GAP_RAND_W = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_tick,
    input  logic                         halt,
    input  logic [3:0]                   speed,
    input  logic [TYPE_W+GAP_RAND_W-1:0] random,
    input  logic [9:0]                   haddress,
    input  logic [9:0]                   vaddress,
    input  logic                         dino_pix,
    input  logic                         obst_pix,
    output logic                         hit,
    output logic [TYPE_W-1:0]            hit_type,
    output logic [4:0]                   local_x,
    output logic [5:0]                   local_y,
    output logic                         collide,
    output logic [NUM_SLOTS-1:0]         active,
    output logic [15:0]                  spawn_count
);

    localparam int unsigned GW = 16;

    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [XW-1:0]        xe_q   [NUM_SLOTS];
    logic [XW-1:0]        xe_d   [NUM_SLOTS];
    logic [TYPE_W-1:0]    type_q [NUM_SLOTS];
    logic [TYPE_W-1:0]    type_d [NUM_SLOTS];
    logic [GW-1:0]        gap_q, gap_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 collide_q, collide_d;
    logic                 hit_q, hit_d;
    logic [TYPE_W-1:0]    hit_type_q, hit_type_d;
    logic [4:0]           local_x_q, local_x_d;
    logic [5:0]           local_y_q, local_y_d;

    logic [NUM_SLOTS-1:0] free, spawn_oh;
    logic                 step;

    // Free set and its lowest-index member come from pre-edge state, so a slot
    // retiring on this tick cannot be reused until the next one.
    assign free     = ~valid_q;
    assign spawn_oh = free & (~free + NUM_SLOTS'(1));
    assign step     = frame_tick && !halt && !collide_q && (speed != 4'd0);

    always_comb begin
        valid_d = valid_q;
        xe_d    = xe_q;
        type_d  = type_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        if (step) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (valid_q[i]) begin
                    if (xe_q[i] <= XW'(speed)) begin
                        valid_d[i] = 1'b0;
                    end else begin
                        xe_d[i] = xe_q[i] - XW'(speed);
                    end
                end
            end
            if (gap_q <= GW'(speed)) begin
                if (|free) begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (spawn_oh[i]) begin
                            valid_d[i] = 1'b1;
                            xe_d[i]    = XW'(SCREEN_W + SPRITE_W);
                            type_d[i]  = random[TYPE_W-1:0];
                        end
                    end
                    gap_d = GW'(MIN_GAP) + GW'(random[TYPE_W+GAP_RAND_W-1:TYPE_W]);
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    // Deferred spawn: fires on the first tick that finds a free slot.
                    gap_d = '0;
                end
            end else begin
                gap_d = gap_q - GW'(speed);
            end
        end
    end

    logic [XW-1:0]     h_ext, sel_xe;
    logic [TYPE_W-1:0] sel_type;
    logic              found, v_in, on_screen;

    assign h_ext     = XW'(haddress);
    assign v_in      = (vaddress >= 10'(Y_TOP)) && (vaddress < 10'(Y_TOP + SPRITE_H));
    assign on_screen = (haddress < 10'(SCREEN_W)) && (vaddress < 10'd480);

    always_comb begin
        found    = 1'b0;
        sel_type = '0;
        sel_xe   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!found && valid_q[i] && (h_ext < xe_q[i]) &&
                (h_ext + XW'(SPRITE_W) >= xe_q[i])) begin
                found    = 1'b1;
                sel_type = type_q[i];
                sel_xe   = xe_q[i];
            end
        end
        hit_d      = found && v_in && on_screen;
        hit_type_d = hit_type_q;
        local_x_d  = local_x_q;
        local_y_d  = local_y_q;
        if (hit_d) begin
            hit_type_d = sel_type;
            local_x_d  = 5'(h_ext + XW'(SPRITE_W) - sel_xe);
            local_y_d  = 6'(vaddress - 10'(Y_TOP));
        end
    end

    assign collide_d = collide_q | (hit_q & dino_pix & obst_pix);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            xe_q       <= '{default: '0};
            type_q     <= '{default: '0};
            gap_q      <= GW'(MIN_GAP);
            cnt_q      <= '0;
            collide_q  <= 1'b0;
            hit_q      <= 1'b0;
            hit_type_q <= '0;
            local_x_q  <= '0;
            local_y_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            xe_q       <= xe_d;
            type_q     <= type_d;
            gap_q      <= gap_d;
            cnt_q      <= cnt_d;
            collide_q  <= collide_d;
            hit_q      <= hit_d;
            hit_type_q <= hit_type_d;
            local_x_q  <= local_x_d;
            local_y_q  <= local_y_d;
        end
    end

    assign hit         = hit_q;
    assign hit_type    = hit_type_q;
    assign local_x     = local_x_q;
    assign local_y     = local_y_q;
    assign collide     = collide_q;
    assign active      = valid_q;
    assign spawn_count = cnt_q;

endmodule

// File: tb/tb_obstacle_manager.sv
// Directed bench for obstacle_manager: scoreboard of expected outputs pushed at drive time,
// popped and compared one edge later. A second instance with a short gap exercises overlap.
module tb_obstacle_manager;

    logic        clk = 1'b0;
    logic        reset, reset2, frame_tick, frame_tick2, halt, dino_pix, obst_pix;
    logic [3:0]  speed;
    logic [8:0]  random;
    logic [9:0]  haddress, vaddress;

    logic        hit, collide, hit2, collide2;
    logic [1:0]  hit_type, hit_type2;
    logic [4:0]  local_x, local_x2;
    logic [5:0]  local_y, local_y2;
    logic [2:0]  active, active2;
    logic [15:0] spawn_count, spawn_count2;

    always #5 clk = ~clk;

    obstacle_manager u_dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .halt(halt), .speed(speed),
        .random(random), .haddress(haddress), .vaddress(vaddress), .dino_pix(dino_pix),
        .obst_pix(obst_pix), .hit(hit), .hit_type(hit_type), .local_x(local_x),
        .local_y(local_y), .collide(collide), .active(active), .spawn_count(spawn_count)
    );

    obstacle_manager #(.MIN_GAP(20)) u_dut2 (
        .clk(clk), .reset(reset2), .frame_tick(frame_tick2), .halt(halt), .speed(speed),
        .random(random), .haddress(haddress), .vaddress(vaddress), .dino_pix(dino_pix),
        .obst_pix(obst_pix), .hit(hit2), .hit_type(hit_type2), .local_x(local_x2),
        .local_y(local_y2), .collide(collide2), .active(active2), .spawn_count(spawn_count2)
    );

    typedef struct {
        int          step;
        bit          sel;
        logic        hit;
        logic [1:0]  typ;
        logic [4:0]  lx;
        logic [5:0]  ly;
        logic        col;
        logic [2:0]  act;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;
    bit   tb_sel   = 1'b0;

    // Expected-output model, updated by the directed steps.
    logic        e_hit, e_col;
    logic [1:0]  e_typ;
    logic [4:0]  e_lx;
    logic [5:0]  e_ly;
    logic [2:0]  e_act;
    logic [15:0] e_cnt;

    task automatic chk_field(input int step, input string name, input logic [15:0] got,
                             input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL step%0d %s observed=%0d expected=%0d", step, name, got, exp);
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        e = sb.pop_front();
        if (e.sel) begin
            chk_field(e.step, "hit2", 16'(hit2), 16'(e.hit));
            chk_field(e.step, "hit_type2", 16'(hit_type2), 16'(e.typ));
            chk_field(e.step, "local_x2", 16'(local_x2), 16'(e.lx));
            chk_field(e.step, "local_y2", 16'(local_y2), 16'(e.ly));
            chk_field(e.step, "collide2", 16'(collide2), 16'(e.col));
            chk_field(e.step, "active2", 16'(active2), 16'(e.act));
            chk_field(e.step, "spawn_count2", spawn_count2, e.cnt);
        end else begin
            chk_field(e.step, "hit", 16'(hit), 16'(e.hit));
            chk_field(e.step, "hit_type", 16'(hit_type), 16'(e.typ));
            chk_field(e.step, "local_x", 16'(local_x), 16'(e.lx));
            chk_field(e.step, "local_y", 16'(local_y), 16'(e.ly));
            chk_field(e.step, "collide", 16'(collide), 16'(e.col));
            chk_field(e.step, "active", 16'(active), 16'(e.act));
            chk_field(e.step, "spawn_count", spawn_count, e.cnt);
        end
    endtask

    task automatic cycle(input bit ft, input bit chk);
        frame_tick  = ft && !tb_sel;
        frame_tick2 = ft && tb_sel;
        if (chk) begin
            step_id++;
            sb.push_back('{step: step_id, sel: tb_sel, hit: e_hit, typ: e_typ, lx: e_lx,
                           ly: e_ly, col: e_col, act: e_act, cnt: e_cnt});
        end
        @(posedge clk);
        #1;
        frame_tick  = 1'b0;
        frame_tick2 = 1'b0;
        if (chk) compare_pop();
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
    endtask

    task automatic query(input int h, input int v, input bit exp_hit, input int typ,
                         input int lx, input int ly);
        haddress = 10'(h);
        vaddress = 10'(v);
        e_hit    = exp_hit;
        if (exp_hit) begin
            e_typ = 2'(typ);
            e_lx  = 5'(lx);
            e_ly  = 6'(ly);
        end
        cycle(1'b0, 1'b1);
    endtask

    task automatic park();
        vaddress = 10'd0;
        e_hit    = 1'b0;
    endtask

    task automatic zero_exp();
        e_hit = 0; e_typ = 0; e_lx = 0; e_ly = 0; e_col = 0; e_act = 0; e_cnt = 0;
    endtask

    initial begin
        reset = 1; reset2 = 1; frame_tick = 0; frame_tick2 = 0; halt = 0;
        dino_pix = 0; obst_pix = 0; speed = 4'd4; random = '0;
        haddress = '0; vaddress = '0;
        zero_exp();
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        reset = 0;

        // First spawn lands on tick 50 at speed 4.
        tick_n(49);
        cycle(1'b0, 1'b1);
        e_act = 3'b001; e_cnt = 16'd1;
        cycle(1'b1, 1'b1);
        query(645, 210, 0, 0, 0, 0);
        query(639, 210, 0, 0, 0, 0);
        tick_n(1);
        query(639, 210, 1, 0, 3, 7);
        query(640, 210, 0, 0, 0, 0);

        // xe = 627 after ten ticks: box edges.
        park();
        tick_n(9);
        query(600, 203, 1, 0, 0, 0);
        query(627, 203, 0, 0, 0, 0);
        query(626, 249, 1, 0, 26, 46);
        query(626, 250, 0, 0, 0, 0);
        query(599, 210, 0, 0, 0, 0);

        park();
        tick_n(39);
        random = 9'd2; e_act = 3'b011; e_cnt = 16'd2;
        cycle(1'b1, 1'b1);
        random = '0;
        tick_n(49);
        random = 9'd3; e_act = 3'b111; e_cnt = 16'd3;
        cycle(1'b1, 1'b1);
        random = '0;

        // All slots busy: spawn deferred until slot 0 retires on tick 217.
        tick_n(66);
        cycle(1'b0, 1'b1);
        e_act = 3'b110;
        cycle(1'b1, 1'b1);
        random = {7'd5, 2'd1}; e_act = 3'b111; e_cnt = 16'd4;
        cycle(1'b1, 1'b1);
        random = '0;
        query(380, 230, 1, 3, 12, 27);
        query(180, 220, 1, 2, 12, 17);

        // Collision needs both pixel inputs together with hit.
        dino_pix = 1;
        query(180, 220, 1, 2, 12, 17);
        obst_pix = 1; e_col = 1;
        query(180, 220, 1, 2, 12, 17);
        dino_pix = 0; obst_pix = 0;
        park();
        tick_n(10);
        cycle(1'b0, 1'b1);
        query(180, 220, 1, 2, 12, 17);
        query(380, 230, 1, 3, 12, 27);

        // Reset wins over a coincident frame tick.
        park();
        reset = 1;
        zero_exp();
        cycle(1'b1, 1'b1);
        reset = 0;
        tick_n(49);
        cycle(1'b0, 1'b1);
        e_act = 3'b001; e_cnt = 16'd1;
        cycle(1'b1, 1'b1);

        // Halt and zero speed freeze motion without touching collide.
        tick_n(5);
        query(630, 210, 1, 0, 10, 7);
        park();
        halt = 1;
        tick_n(20);
        cycle(1'b0, 1'b1);
        query(630, 210, 1, 0, 10, 7);
        park();
        halt = 0;
        cycle(1'b1, 1'b1);
        query(630, 210, 1, 0, 14, 7);
        park();
        speed = 4'd0;
        tick_n(3);
        query(630, 210, 1, 0, 14, 7);
        park();

        // Short-gap instance: two overlapping boxes, lower index wins.
        tb_sel = 1;
        zero_exp();
        cycle(1'b0, 1'b1);
        reset2 = 0;
        speed  = 4'd10;
        cycle(1'b1, 1'b0);
        random = 9'd1; e_act = 3'b001; e_cnt = 16'd1;
        cycle(1'b1, 1'b1);
        random = '0;
        cycle(1'b1, 1'b0);
        random = 9'd2; e_act = 3'b011; e_cnt = 16'd2;
        cycle(1'b1, 1'b1);
        random = '0;
        cycle(1'b1, 1'b1);
        query(632, 210, 1, 1, 22, 7);
        query(636, 210, 1, 1, 26, 7);
        query(638, 210, 1, 2, 8, 7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/obstacle_manager.md
Name: obstacle_manager

Overview:
Parametrised obstacle engine for the runner game. It replaces the fixed three-cactus select/type logic with NUM_SLOTS independent obstacle slots. Each slot has its own position, its own sprite type drawn from the RNG, and its own lifetime, and spawning is driven by a randomised gap counter. Each frame the block scrolls all active obstacles. Each pixel it answers "which obstacle covers (haddress,vaddress), and at what sprite-local coordinate". It also latches the dino/obstacle collision.

Parameters:
NUM_SLOTS, 3, number of concurrent obstacle slots (1..8)
XW, 11, width of slot position registers
TYPE_W, 2, width of sprite type code per slot
SCREEN_W, 640, visible width; obstacles spawn just beyond it
SPRITE_W, 27, obstacle bounding-box width in pixels
SPRITE_H, 47, obstacle bounding-box height in pixels
Y_TOP, 203, top scanline of the obstacle box
MIN_GAP, 200, minimum scroll distance between spawns
GAP_RAND_W, 7, random bits added to MIN_GAP

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame (vsync start)
halt  in  1  freeze motion and spawning
speed  in  4  scroll pixels per frame
random  in  TYPE_W+GAP_RAND_W  RNG sample
haddress  in  10  current pixel column
vaddress  in  10  current pixel row
dino_pix  in  1  dino sprite pixel, aligned with hit
obst_pix  in  1  obstacle ROM pixel addressed by hit_type/local_x/local_y
hit  out  1  an obstacle box covers the previous-cycle pixel
hit_type  out  TYPE_W  type of the covering slot
local_x  out  5  column within sprite
local_y  out  6  row within sprite
collide  out  1  sticky collision flag
active  out  NUM_SLOTS  per-slot valid bits
spawn_count  out  16  obstacles spawned since reset, saturating

Behaviour:
- Slot state: valid, xe (right edge exclusive, XW bits, unsigned), type. The box covers columns [xe-SPRITE_W, xe); off-left clipping needs no signed math.
- Reset:
  - All slots invalid, gap_cnt=MIN_GAP.
  - collide=0, hit=0, hit_type=0, local_x=0, local_y=0, spawn_count=0.
  - Reset beats a coincident frame_tick.
- Frozen = halt | collide, using register values before the edge. A frame_tick while frozen, or with speed=0, changes no slot or gap_cnt state.
- On each unfrozen frame_tick, for every valid slot:
  - if xe <= speed, the slot retires (valid=0);
  - otherwise xe -= speed.
- Spawn, evaluated in the same frame_tick:
  - If gap_cnt <= speed and a slot was free before this edge, the lowest-index free slot is loaded with valid=1, xe=SCREEN_W+SPRITE_W, type=random[TYPE_W-1:0].
  - On a spawn, gap_cnt=MIN_GAP+random[TYPE_W+GAP_RAND_W-1:TYPE_W] and spawn_count increments, saturating at 0xFFFF.
  - A freshly spawned slot is not moved on its spawn tick.
  - A slot retiring on this tick is not reusable until the next tick.
  - If gap_cnt <= speed and no slot is free, gap_cnt is set to 0 and the spawn is deferred to the first tick that finds a free slot.
  - Otherwise gap_cnt -= speed.
- Pixel query, 1-cycle latency:
  - Slot i is in-box when haddress < xe_i, haddress+SPRITE_W >= xe_i, and Y_TOP <= vaddress < Y_TOP+SPRITE_H.
  - Widen to XW bits before adding.
  - The lowest-index in-box slot wins.
  - Registered outputs: hit=1, hit_type=type, local_x=haddress+SPRITE_W-xe, local_y=vaddress-Y_TOP.
  - If no slot is in-box, or haddress>=640, or vaddress>=480: hit=0 and the other query outputs hold their previous values.
- Collision: collide is set on any edge where hit & dino_pix & obst_pix. It is cleared only by reset.
- active mirrors the valid bits.

Test Plan:
- Reset, speed=4, random=0, haddress=0, vaddress=0, NUM_SLOTS=3:
  - ticks 1..49: no spawn, gap_cnt reaches 4;
  - tick 50: slot0 valid, xe=667, active=3'b001, spawn_count=1.
- Ten ticks after that spawn, xe=627. Drive haddress=600, vaddress=203 -> next cycle hit=1, local_x=0, local_y=0. Drive haddress=627 -> hit=0. Drive vaddress=250 -> hit=0.
- Keep ticking at speed=4:
  - xe steps 667, 663, ..., 7, 3;
  - tick 167 after the spawn retires the slot (3<=4), active[0]=0.
- Force every slot valid (speed=15, random=0) and let gap_cnt expire -> gap_cnt=0, spawn_count unchanged. The first tick after a retirement spawns into the freed lowest index.
- Collision and halt:
  - hit=1 with dino_pix=1, obst_pix=1 -> collide=1 next edge; subsequent frame_ticks leave every xe, gap_cnt and spawn_count unchanged; only reset clears collide;
  - halt=1 gives the same freeze without setting collide.
- Two slots overlapping the same pixel -> hit_type and local_x come from the lower index. Assert reset coincident with frame_tick -> all slots invalid, gap_cnt=200.
